cu_state_sequencer: RTL and testbench

Multicycle control-unit state sequencer: drives the 4-bit `curr_state` code consumed by `CU_main_decoder`, advancing through the instruction phases based on the fetched opcode and a memory-ready handshake. It sits beside the main decoder in the control unit, and produces an illegal-opcode trap flag and a retired-instruction counter. `curr_state` encodings match the main decoder's state macros exactly.

---
 rtl/cu_state_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_cu_state_sequencer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/cu_state_sequencer.sv
// ----------------------------------------------------------------------------
// cu_state_sequencer
//
// Multicycle control-unit state sequencer. It produces the 4-bit state code
// that CU_main_decoder consumes. The state advances through the instruction
// phases using the fetched opcode and a memory-ready handshake. The block also
// raises a sticky illegal-opcode trap flag and keeps a count of retired
// instructions.
//
// Parameters:
//   CNT_W          width of the retired-instruction counter (wraps silently)
//
// Ports:
//   clk            in   1      rising-edge clock
//   rst            in   1      synchronous, active-high reset
//   opcode         in   7      instruction bits [6:0] from the IR
//   mem_ready      in   1      memory access completes this cycle
//   curr_state     out  4      registered state code for CU_main_decoder
//   trap           out  1      sticky illegal-opcode flag
//   instr_retired  out  1      one-cycle pulse in the first FETCH cycle after
//                              an instruction completes
//   retired_count  out  CNT_W  completed-instruction count, modulo 2^CNT_W
//
// Handshake: mem_ready acts as the "ready" half of a memory request. The
// request is implied by being in FETCH, MEM_READ or MEM_WRITE. A phase
// completes on any rising edge where the sequencer is in one of those states
// and mem_ready is 1. In every other state mem_ready is ignored.
// ----------------------------------------------------------------------------
module cu_state_sequencer #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       opcode,
    input  logic             mem_ready,
    output logic [3:0]       curr_state,
    output logic             trap,
    output logic             instr_retired,
    output logic [CNT_W-1:0] retired_count
);

    // These encodings must match the main decoder's state macros.
    // TRAP (10) lands in the decoder's all-zero default case, so it is inert.
    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADR   = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXECUTE_R = 4'd6,
        S_ALU_WB    = 4'd7,
        S_EXECUTE_I = 4'd8,
        S_BNEZ      = 4'd9,
        S_TRAP      = 4'd10
    } state_t;

    typedef enum logic [2:0] {
        C_LOAD    = 3'd0,
        C_STORE   = 3'd1,
        C_RTYPE   = 3'd2,
        C_ITYPE   = 3'd3,
        C_BRANCH  = 3'd4,
        C_ILLEGAL = 3'd5
    } class_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           r_state;
    class_t           r_class;
    logic             r_trap;
    logic             r_instr_retired;
    logic [CNT_W-1:0] r_retired_count;

    class_t           w_class;

    // Classify the live opcode. Only DECODE looks at this result.
    always_comb begin
        w_class = C_ILLEGAL;
        case (opcode)
            7'b0000011: w_class = C_LOAD;
            7'b0100011: w_class = C_STORE;
            7'b0110011: w_class = C_RTYPE;
            7'b0010011: w_class = C_ITYPE;
            7'b1100011: w_class = C_BRANCH;
            default:    w_class = C_ILLEGAL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= S_FETCH;
            r_class         <= C_LOAD;
            r_trap          <= 1'b0;
            r_instr_retired <= 1'b0;
            r_retired_count <= '0;
        end else begin
            // Retirement is a one-cycle pulse. It is set only on the edge
            // that takes the sequencer back into FETCH.
            r_instr_retired <= 1'b0;

            case (r_state)
                S_FETCH: begin
                    if (mem_ready) begin
                        r_state <= S_DECODE;
                    end
                end

                S_DECODE: begin
                    // Latch the class here. MEM_ADR must not depend on the
                    // IR staying stable.
                    r_class <= w_class;
                    case (w_class)
                        C_LOAD, C_STORE: r_state <= S_MEM_ADR;
                        C_RTYPE:         r_state <= S_EXECUTE_R;
                        C_ITYPE:         r_state <= S_EXECUTE_I;
                        C_BRANCH:        r_state <= S_BNEZ;
                        default: begin
                            r_state <= S_TRAP;
                            r_trap  <= 1'b1;
                        end
                    endcase
                end

                S_MEM_ADR: begin
                    // Only LOAD or STORE can reach this state.
                    if (r_class == C_STORE) begin
                        r_state <= S_MEM_WRITE;
                    end else begin
                        r_state <= S_MEM_READ;
                    end
                end

                S_MEM_READ: begin
                    if (mem_ready) begin
                        r_state <= S_MEM_WB;
                    end
                end

                S_MEM_WB: begin
                    r_state         <= S_FETCH;
                    r_instr_retired <= 1'b1;
                    r_retired_count <= r_retired_count + CNT_ONE;
                end

                S_MEM_WRITE: begin
                    if (mem_ready) begin
                        r_state         <= S_FETCH;
                        r_instr_retired <= 1'b1;
                        r_retired_count <= r_retired_count + CNT_ONE;
                    end
                end

                S_EXECUTE_R, S_EXECUTE_I: begin
                    r_state <= S_ALU_WB;
                end

                S_ALU_WB, S_BNEZ: begin
                    r_state         <= S_FETCH;
                    r_instr_retired <= 1'b1;
                    r_retired_count <= r_retired_count + CNT_ONE;
                end

                S_TRAP: begin
                    // Only rst leaves this state.
                    r_state <= S_TRAP;
                end

                default: begin
                    // Codes 11-15 are unreachable. Recover to FETCH.
                    r_state <= S_FETCH;
                end
            endcase
        end
    end

    assign curr_state    = r_state;
    assign trap          = r_trap;
    assign instr_retired = r_instr_retired;
    assign retired_count = r_retired_count;

endmodule

// File: tb/tb_cu_state_sequencer.sv
module tb_cu_state_sequencer;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_BAD    = 7'b1111111;

    logic        clk;
    logic        rst;
    logic [6:0]  opcode;
    logic        mem_ready;

    logic [3:0]  curr_state;
    logic        trap;
    logic        instr_retired;
    logic [31:0] retired_count;

    logic [3:0]  curr_state_4;
    logic        trap_4;
    logic        instr_retired_4;
    logic [3:0]  retired_count_4;

    int n_tests;
    int n_fail;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit exceeded");
        $fatal(1, "watchdog");
    end

    cu_state_sequencer #(.CNT_W(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .opcode        (opcode),
        .mem_ready     (mem_ready),
        .curr_state    (curr_state),
        .trap          (trap),
        .instr_retired (instr_retired),
        .retired_count (retired_count)
    );

    cu_state_sequencer #(.CNT_W(4)) dut4 (
        .clk           (clk),
        .rst           (rst),
        .opcode        (opcode),
        .mem_ready     (mem_ready),
        .curr_state    (curr_state_4),
        .trap          (trap_4),
        .instr_retired (instr_retired_4),
        .retired_count (retired_count_4)
    );

    // ---------------- driver tasks ----------------
    // Advance one rising edge. Outputs are then sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One edge, then check the state code and the retire pulse.
    task automatic step(input string tag, input logic [3:0] exp_state, input logic exp_ret);
        tick();
        chk({tag, ".state"}, {28'd0, curr_state}, {28'd0, exp_state});
        chk({tag, ".ret"}, {31'd0, instr_retired}, {31'd0, exp_ret});
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        n_tests   = 0;
        n_fail    = 0;
        rst       = 1'b1;
        opcode    = 7'd0;
        mem_ready = 1'b0;
        tick();
        tick();

        // Reset values
        chk("rst.state", {28'd0, curr_state}, 32'd0);
        chk("rst.trap",  {31'd0, trap}, 32'd0);
        chk("rst.ret",   {31'd0, instr_retired}, 32'd0);
        chk("rst.count", retired_count, 32'd0);
        rst = 1'b0;

        // FETCH holds while mem_ready is low
        step("fetch_wait", 4'd0, 1'b0);

        // LOAD: 0,1,2,3,4,0
        opcode    = OP_LOAD;
        mem_ready = 1'b1;
        step("load.d",  4'd1, 1'b0);
        step("load.a",  4'd2, 1'b0);
        step("load.r",  4'd3, 1'b0);
        step("load.wb", 4'd4, 1'b0);
        chk("load.count_pre", retired_count, 32'd0);
        step("load.f",  4'd0, 1'b1);
        chk("load.count", retired_count, 32'd1);

        // STORE with mem_ready low for 3 cycles in MEM_WRITE
        opcode = OP_STORE;
        step("st.d", 4'd1, 1'b0);
        step("st.a", 4'd2, 1'b0);
        mem_ready = 1'b0;
        step("st.w0", 4'd5, 1'b0);
        step("st.w1", 4'd5, 1'b0);
        step("st.w2", 4'd5, 1'b0);
        step("st.w3", 4'd5, 1'b0);
        chk("st.count_wait", retired_count, 32'd1);
        mem_ready = 1'b1;
        step("st.f", 4'd0, 1'b1);
        chk("st.count", retired_count, 32'd2);

        // Back-to-back RTYPE, ITYPE, BRANCH from a clean reset
        do_reset();
        chk("b2b.count0", retired_count, 32'd0);
        opcode = OP_RTYPE;
        step("r.d",   4'd1, 1'b0);
        step("r.x",   4'd6, 1'b0);
        step("r.wb",  4'd7, 1'b0);
        step("r.f",   4'd0, 1'b1);
        opcode = OP_ITYPE;
        step("i.d",   4'd1, 1'b0);
        step("i.x",   4'd8, 1'b0);
        step("i.wb",  4'd7, 1'b0);
        step("i.f",   4'd0, 1'b1);
        opcode = OP_BRANCH;
        step("b.d",   4'd1, 1'b0);
        step("b.x",   4'd9, 1'b0);
        step("b.f",   4'd0, 1'b1);
        chk("b2b.count", retired_count, 32'd3);

        // Illegal opcode: trap and hold for 20 cycles
        opcode = OP_BAD;
        step("ill.d", 4'd1, 1'b0);
        step("ill.t", 4'd10, 1'b0);
        chk("ill.trap", {31'd0, trap}, 32'd1);
        for (int i = 0; i < 20; i++) begin
            mem_ready = i[0];
            opcode    = (i % 3 == 0) ? OP_LOAD : OP_BAD;
            step("ill.hold", 4'd10, 1'b0);
            chk("ill.hold_trap", {31'd0, trap}, 32'd1);
        end
        chk("ill.count", retired_count, 32'd3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("ill.rst_state", {28'd0, curr_state}, 32'd0);
        chk("ill.rst_trap",  {31'd0, trap}, 32'd0);
        chk("ill.rst_count", retired_count, 32'd0);

        // MEM_ADR uses the latched class; then reset during a MEM_READ wait
        mem_ready = 1'b1;
        opcode    = OP_LOAD;
        step("lat.d", 4'd1, 1'b0);
        step("lat.a", 4'd2, 1'b0);
        opcode    = OP_STORE;
        step("lat.r", 4'd3, 1'b0);
        mem_ready = 1'b0;
        step("lat.hold", 4'd3, 1'b0);
        rst = 1'b1;
        step("mrst", 4'd0, 1'b0);
        chk("mrst.count", retired_count, 32'd0);
        rst = 1'b0;
        step("mrst.idle", 4'd0, 1'b0);

        // Counter wrap on a 4-bit instance: 17 ITYPE instructions
        mem_ready = 1'b1;
        opcode    = OP_ITYPE;
        for (int k = 1; k <= 17; k++) begin
            tick();
            tick();
            tick();
            tick();
            chk("wrap.state4", {28'd0, curr_state_4}, 32'd0);
            chk("wrap.ret4",   {31'd0, instr_retired_4}, 32'd1);
            chk("wrap.count4", {28'd0, retired_count_4}, k % 16);
            chk("wrap.count32", retired_count, k);
        end
        chk("wrap.trap4", {31'd0, trap_4}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
